// File: rtl/mac_tcdm_mux.sv
// Round-robin funnel of MP TCDM master ports onto one memory port; an in-order ID FIFO steers responses back.
// Optional MAC_TCDM_MUX_PERF_EN compiles a saturating stall counter onto perf_stall_o (tied to 0 otherwise).
package mac_tcdm_mux_pkg;
    typedef struct packed {
        logic [31:0] add;
        logic        wen;
        logic [3:0]  be;
        logic [31:0] data;
    } tcdm_req_t;
endpackage

module mac_tcdm_mux_port
    import mac_tcdm_mux_pkg::*;
#(
    parameter int PW  = 2,
    parameter int IDX = 0
) (
    input  logic [31:0]   add,
    input  logic          wen,
    input  logic [3:0]    be,
    input  logic [31:0]   data,
    input  logic [PW-1:0] winner,
    input  logic          hs,
    input  logic [PW-1:0] head,
    input  logic          pop,
    input  logic [31:0]   r_data_bcast,
    output tcdm_req_t     req_fields,
    output logic          gnt,
    output logic          r_valid,
    output logic [31:0]   r_data
);
    assign req_fields = '{add: add, wen: wen, be: be, data: data};
    assign gnt        = hs && (winner == PW'(IDX));
    assign r_valid    = pop && (head == PW'(IDX));
    assign r_data     = r_data_bcast;
endmodule

module mac_tcdm_mux
    import mac_tcdm_mux_pkg::*;
#(
    parameter int MP         = 4,
    parameter int NB_OUTSTND = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [MP-1:0]    in_req,
    output logic [MP-1:0]    in_gnt,
    input  logic [MP*32-1:0] in_add,
    input  logic [MP-1:0]    in_wen,
    input  logic [MP*4-1:0]  in_be,
    input  logic [MP*32-1:0] in_data,
    output logic [MP*32-1:0] in_r_data,
    output logic [MP-1:0]    in_r_valid,
    output logic             out_req,
    input  logic             out_gnt,
    output logic [31:0]      out_add,
    output logic             out_wen,
    output logic [3:0]       out_be,
    output logic [31:0]      out_data,
    input  logic [31:0]      out_r_data,
    input  logic             out_r_valid,
    output logic             err_o,
    output logic [31:0]      perf_stall_o
);
    localparam int PW = $clog2(MP);
    localparam int FW = $clog2(NB_OUTSTND);

    logic [PW-1:0]                 rr_ptr, winner, head;
    logic [NB_OUTSTND-1:0][PW-1:0] id_fifo;
    logic [FW-1:0]                 wr_ptr, rd_ptr;
    logic [FW:0]                   cnt;
    logic                          full, empty, can_push, hs, pop;
    tcdm_req_t [MP-1:0]            port_req;
    tcdm_req_t                     sel;

    // Descending scan so the lowest offset from rr_ptr is written last and wins.
    always_comb begin
        int j;
        j      = 0;
        winner = rr_ptr;
        for (int i = MP - 1; i >= 0; i--) begin
            j = int'(rr_ptr) + i;
            if (j >= MP) j = j - MP;
            if (in_req[j]) winner = PW'(j);
        end
    end

    assign full     = (cnt == (FW+1)'(NB_OUTSTND));
    assign empty    = (cnt == '0);
    assign can_push = !full || out_r_valid;
    assign out_req  = (|in_req) && can_push;
    assign hs       = out_req && out_gnt;
    assign pop      = out_r_valid && !empty;
    assign head     = id_fifo[rd_ptr];

    assign sel      = out_req ? port_req[winner] : '0;
    assign out_add  = sel.add;
    assign out_wen  = sel.wen;
    assign out_be   = sel.be;
    assign out_data = sel.data;

    for (genvar k = 0; k < MP; k++) begin : g_port
        mac_tcdm_mux_port #(.PW(PW), .IDX(k)) u_port (
            .add          (in_add[k*32+:32]),
            .wen          (in_wen[k]),
            .be           (in_be[k*4+:4]),
            .data         (in_data[k*32+:32]),
            .winner       (winner),
            .hs           (hs),
            .head         (head),
            .pop          (pop),
            .r_data_bcast (out_r_data),
            .req_fields   (port_req[k]),
            .gnt          (in_gnt[k]),
            .r_valid      (in_r_valid[k]),
            .r_data       (in_r_data[k*32+:32])
        );
    end

    always_ff @(posedge clk_i) begin
        if (hs) id_fifo[wr_ptr] <= winner;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            err_o  <= 1'b0;
        end else begin
            if (hs) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= (winner == PW'(MP - 1)) ? '0 : winner + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (hs && !pop)      cnt <= cnt + 1'b1;
            else if (!hs && pop) cnt <= cnt - 1'b1;
            // A response with nothing outstanding means the memory broke its contract.
            if (out_r_valid && empty) err_o <= 1'b1;
        end
    end

`ifdef MAC_TCDM_MUX_PERF_EN
    logic [31:0] stall_cnt;
    always_ff @(posedge clk_i) begin
        if (rst_i)                               stall_cnt <= '0;
        else if ((|in_req) && !hs && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
    assign perf_stall_o = stall_cnt;
`else
    assign perf_stall_o = '0;
`endif
endmodule
